// File: rtl/crypto_wallet2_trng_collector.sv
// crypto_wallet2_trng_collector
// Entropy collector feeding the 32-bit random-word PIO read by the Nios.
// A ring-oscillator noise bit is synchronised, sampled every SAMPLE_DIV clocks,
// debiased with a von Neumann corrector and shifted into a 32-bit accumulator.
// A full word is published (optionally XOR-whitened with a free-running Galois
// LFSR) with word_valid; firmware consumes it by raising next_req.
//
// Optional build macro: TRNG_HEALTH_EN
//   defined   -> repetition-count health test and terminal FAIL state
//   undefined -> no repetition counter, health_fail tied low
//
// state   | meaning
// COLLECT | sampling noise and assembling corrected bits
// FULL    | word published, sampling frozen, waiting for next_req
// FAIL    | health test tripped, terminal until reset_n (TRNG_HEALTH_EN only)

module crypto_wallet2_trng_collector #(
    parameter int unsigned SAMPLE_DIV = 16,
    parameter bit          WHITEN     = 1'b1,
    parameter logic [31:0] LFSR_SEED  = 32'h1234_5678,
    parameter int unsigned REP_LIMIT  = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        noise_in,
    input  logic        next_req,
    output logic [31:0] rand_word,
    output logic        word_valid,
    output logic        health_fail,
    output logic [5:0]  bit_count
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_FULL    = 2'd1;
`ifdef TRNG_HEALTH_EN
    localparam logic [1:0] ST_FAIL    = 2'd2;
`endif

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [5:0]  WORD_BITS = 6'd32;

    localparam int unsigned        CNT_W    = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    // Parameter sanity: a divider below 2 breaks the strobe/publish spacing,
    // a zero seed locks the LFSR, a zero limit would trip on every strobe.
    if (SAMPLE_DIV < 2) begin : g_chk_div
        $error("SAMPLE_DIV must be at least 2");
    end
    if (LFSR_SEED == 32'd0) begin : g_chk_seed
        $error("LFSR_SEED must be nonzero");
    end
    if (REP_LIMIT < 1) begin : g_chk_rep
        $error("REP_LIMIT must be at least 1");
    end

    logic             noise_meta_q;
    logic             ns_q;

    logic [1:0]       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             have_a_q,     have_a_d;
    logic             a_q,          a_d;
    logic [31:0]      accum_q,      accum_d;
    logic [5:0]       bit_count_q,  bit_count_d;
    logic [31:0]      lfsr_q,       lfsr_d;
    logic [31:0]      rand_word_q,  rand_word_d;
    logic             word_valid_q, word_valid_d;

    logic             in_collect;
    logic             publish;
    logic             strobe;

`ifdef TRNG_HEALTH_EN
    localparam int unsigned      REP_W    = $clog2(REP_LIMIT + 1);
    localparam logic [REP_W-1:0] REP_TRIP = REP_W'(REP_LIMIT);

    logic [REP_W-1:0] rep_q,         rep_d;
    logic             prev_q,        prev_d;
    logic             health_fail_q, health_fail_d;
`endif

    assign in_collect = (state_q == ST_COLLECT);
    // Publishing takes the whole cycle after the 32nd bit lands; no sample
    // can be accepted on top of a complete word.
    assign publish    = in_collect && (bit_count_q == WORD_BITS);
    assign strobe     = in_collect && !publish && (cnt_q == CNT_LAST);

    // Two-flop synchroniser for the asynchronous ring-oscillator bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            noise_meta_q <= 1'b0;
            ns_q         <= 1'b0;
        end else begin
            noise_meta_q <= noise_in;
            ns_q         <= noise_meta_q;
        end
    end

    // Next-state logic: sample divider, von Neumann pairing, publish/consume FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        have_a_d     = have_a_q;
        a_d          = a_q;
        accum_d      = accum_q;
        bit_count_d  = bit_count_q;
        rand_word_d  = rand_word_q;
        word_valid_d = word_valid_q;
        lfsr_d       = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
`ifdef TRNG_HEALTH_EN
        rep_d         = rep_q;
        prev_d        = prev_q;
        health_fail_d = health_fail_q;
`endif

        // Counter runs only while collecting; it restarts from 0 on every
        // return to COLLECT so sampling phase is the same after reset or consume.
        if (!in_collect || publish || strobe) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Non-overlapping pairs: first strobe latches a, second decides.
        if (strobe) begin
            if (!have_a_q) begin
                a_d      = ns_q;
                have_a_d = 1'b1;
            end else begin
                have_a_d = 1'b0;
                if (a_q != ns_q) begin
                    accum_d     = {accum_q[30:0], a_q};
                    bit_count_d = bit_count_q + 6'd1;
                end
            end
        end

        if (publish) begin
            rand_word_d  = WHITEN ? (accum_q ^ lfsr_q) : accum_q;
            word_valid_d = 1'b1;
            state_d      = ST_FULL;
        end

        // next_req is only honoured in FULL, so a request held through the
        // publish cycle cannot swallow a word that was never visible.
        if ((state_q == ST_FULL) && next_req) begin
            state_d      = ST_COLLECT;
            word_valid_d = 1'b0;
            bit_count_d  = 6'd0;
            have_a_d     = 1'b0;
        end

`ifdef TRNG_HEALTH_EN
        // Repetition count on raw samples; first sample after reset compares
        // against the reset value of prev, which is harmless for a run count.
        if (strobe) begin
            prev_d = ns_q;
            if (ns_q == prev_q) begin
                rep_d = (rep_q == REP_TRIP) ? rep_q : rep_q + REP_W'(1);
            end else begin
                rep_d = REP_W'(1);
            end
            if (rep_d == REP_TRIP) begin
                state_d       = ST_FAIL;
                health_fail_d = 1'b1;
                word_valid_d  = 1'b0;
            end
        end
`endif
    end

    // Main state registers; reset discards any partial word without publishing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_COLLECT;
            cnt_q        <= '0;
            have_a_q     <= 1'b0;
            a_q          <= 1'b0;
            accum_q      <= 32'd0;
            bit_count_q  <= 6'd0;
            lfsr_q       <= LFSR_SEED;
            rand_word_q  <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            have_a_q     <= have_a_d;
            a_q          <= a_d;
            accum_q      <= accum_d;
            bit_count_q  <= bit_count_d;
            lfsr_q       <= lfsr_d;
            rand_word_q  <= rand_word_d;
            word_valid_q <= word_valid_d;
        end
    end

`ifdef TRNG_HEALTH_EN
    // Health-test registers; health_fail is sticky until reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_q         <= '0;
            prev_q        <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            rep_q         <= rep_d;
            prev_q        <= prev_d;
            health_fail_q <= health_fail_d;
        end
    end

    assign health_fail = health_fail_q;
`else
    assign health_fail = 1'b0;
`endif

    assign rand_word  = rand_word_q;
    assign word_valid = word_valid_q;
    assign bit_count  = bit_count_q;

endmodule

// File: tb/tb_crypto_wallet2_trng_collector.sv
// Directed bench for crypto_wallet2_trng_collector.
// Main instance runs unwhitened so words can be checked against literal
// patterns; a second whitened instance shares the stimulus and is checked
// against a reference Galois LFSR at the first publish.
// Optional build macro TRNG_HEALTH_EN switches the health-test expectations.

module tb_crypto_wallet2_trng_collector;

    localparam int          D         = 4;
    localparam logic [31:0] SEED      = 32'h1234_5678;
    localparam logic [31:0] TAPS      = 32'h8020_0003;
`ifdef TRNG_HEALTH_EN
    localparam bit          HEALTH_ON = 1'b1;
`else
    localparam bit          HEALTH_ON = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        noise_in = 1'b0;
    logic        next_req = 1'b0;

    logic [31:0] rand_word;
    logic        word_valid;
    logic        health_fail;
    logic [5:0]  bit_count;

    logic [31:0] rand_word_w;
    logic        word_valid_w;
    logic        health_fail_w;
    logic [5:0]  bit_count_w;

    logic [31:0] lfsr_m;
    logic [31:0] lfsr_prev;

    int tests_run    = 0;
    int tests_failed = 0;

    crypto_wallet2_trng_collector #(
        .SAMPLE_DIV (D),
        .WHITEN     (1'b0),
        .LFSR_SEED  (SEED),
        .REP_LIMIT  (32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .noise_in    (noise_in),
        .next_req    (next_req),
        .rand_word   (rand_word),
        .word_valid  (word_valid),
        .health_fail (health_fail),
        .bit_count   (bit_count)
    );

    crypto_wallet2_trng_collector #(
        .SAMPLE_DIV (D),
        .WHITEN     (1'b1),
        .LFSR_SEED  (SEED),
        .REP_LIMIT  (32)
    ) dut_w (
        .clk         (clk),
        .reset_n     (reset_n),
        .noise_in    (noise_in),
        .next_req    (next_req),
        .rand_word   (rand_word_w),
        .word_valid  (word_valid_w),
        .health_fail (health_fail_w),
        .bit_count   (bit_count_w)
    );

    always #5 clk = ~clk;

    // Reference whitening LFSR; lfsr_prev is the value seen before the last edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_m    <= SEED;
            lfsr_prev <= SEED;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= {1'b0, lfsr_m[31:1]} ^ (lfsr_m[0] ? TAPS : 32'd0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One raw sample period; starts and ends on a negedge, aligned to the strobe.
    task automatic raw(input logic b);
        noise_in = b;
        repeat (D) @(posedge clk);
        @(negedge clk);
    endtask

    // Sends the top n bits of w as 10/01 pairs, optionally preceded by 00 and 11.
    task automatic send_bits(input logic [31:0] w, input int n, input bit ilv, input int start);
        int   exp_bc;
        logic b;
        exp_bc = start;
        for (int i = 0; i < n; i++) begin
            b = w[31-i];
            if (ilv) begin
                raw(1'b0);
                raw(1'b0);
                chk("discard00_bit_count", 32'(bit_count), 32'(exp_bc));
                raw(1'b1);
                raw(1'b1);
                chk("discard11_bit_count", 32'(bit_count), 32'(exp_bc));
            end
            raw(b);
            raw(~b);
            exp_bc++;
            if (ilv) chk("accept_bit_count", 32'(bit_count), 32'(exp_bc));
        end
    endtask

    // Entered right after the 32nd bit lands; checks the publish one clk later.
    task automatic check_publish(input logic [31:0] exp_word, input logic [31:0] held_word);
        chk("pre_publish_bit_count", 32'(bit_count), 32'd32);
        chk("pre_publish_valid", 32'(word_valid), 32'd0);
        chk("pre_publish_word_held", rand_word, held_word);
        @(posedge clk);
        @(negedge clk);
        chk("publish_valid", 32'(word_valid), 32'd1);
        chk("publish_word", rand_word, exp_word);
    endtask

    task automatic consume_pulse(input logic [31:0] held_word);
        next_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        next_req = 1'b0;
        chk("consume_valid", 32'(word_valid), 32'd0);
        chk("consume_bit_count", 32'(bit_count), 32'd0);
        chk("consume_word_held", rand_word, held_word);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_word", rand_word, 32'd0);
        chk("reset_valid", 32'(word_valid), 32'd0);
        chk("reset_health", 32'(health_fail), 32'd0);
        chk("reset_bit_count", 32'(bit_count), 32'd0);
        reset_n = 1'b1;

        // 1: plain collection of 0xA5A5A5A5
        send_bits(32'hA5A5_A5A5, 32, 1'b0, 0);
        check_publish(32'hA5A5_A5A5, 32'd0);
        chk("whiten_word", rand_word_w, 32'hA5A5_A5A5 ^ lfsr_prev);
        chk("whiten_valid", 32'(word_valid_w), 32'd1);

        // FULL holds: sampling frozen, word stays valid without next_req
        raw(1'b1);
        raw(1'b0);
        chk("full_hold_valid", 32'(word_valid), 32'd1);
        chk("full_hold_bit_count", 32'(bit_count), 32'd32);

        // 3: single-cycle next_req consumes
        consume_pulse(32'hA5A5_A5A5);

        // 2: discarded 00/11 pairs interleaved, same final word
        send_bits(32'hA5A5_A5A5, 32, 1'b1, 0);
        check_publish(32'hA5A5_A5A5, 32'hA5A5_A5A5);

        // 3 (cont.): rand_word held through a new collection until publish
        consume_pulse(32'hA5A5_A5A5);
        send_bits(32'h3C96_E10F, 32, 1'b0, 0);
        check_publish(32'h3C96_E10F, 32'hA5A5_A5A5);

        // 4: next_req held high through COLLECT and the publish cycle
        next_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("held_req_consume_valid", 32'(word_valid), 32'd0);
        send_bits(32'h0F0F_1234, 32, 1'b0, 0);
        check_publish(32'h0F0F_1234, 32'h3C96_E10F);
        @(posedge clk);
        @(negedge clk);
        chk("held_req_clear_valid", 32'(word_valid), 32'd0);
        chk("held_req_clear_bit_count", 32'(bit_count), 32'd0);
        chk("held_req_word_held", rand_word, 32'h0F0F_1234);
        next_req = 1'b0;

        // 5: reset at bit_count=17, then a fresh collection
        send_bits(32'hDEAD_BEEF, 17, 1'b0, 0);
        chk("partial_bit_count", 32'(bit_count), 32'd17);
        reset_n = 1'b0;
        #1;
        chk("midreset_word", rand_word, 32'd0);
        chk("midreset_valid", 32'(word_valid), 32'd0);
        chk("midreset_health", 32'(health_fail), 32'd0);
        chk("midreset_bit_count", 32'(bit_count), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send_bits(32'h1357_9BDF, 32, 1'b0, 0);
        check_publish(32'h1357_9BDF, 32'd0);

        // 6: stuck-at-1 noise, repetition-count health test
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 31; i++) raw(1'b1);
        chk("health_before_limit", 32'(health_fail), 32'd0);
        raw(1'b1);
        chk("health_at_limit", 32'(health_fail), 32'(HEALTH_ON));
        chk("health_valid", 32'(word_valid), 32'd0);
        chk("health_bit_count", 32'(bit_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            raw(1'b1);
            raw(1'b0);
        end
        chk("health_stuck_bit_count", 32'(bit_count), HEALTH_ON ? 32'd0 : 32'd4);
        chk("health_sticky", 32'(health_fail), 32'(HEALTH_ON));
        reset_n = 1'b0;
        #1;
        chk("health_reset_clears", 32'(health_fail), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
